// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates an instruction-fetch requester and a data requester
// onto an 8-bit RAM/IO bus. Each 1/2/4-byte access is serialised into byte
// transfers, and read bytes are reassembled little-endian and zero-filled.
// Optional build macro: IO_FULL_STALL_EN. When it is defined, a MEM write
// into the IO window (address[17:16] == 2'b11) waits while io_buffer_full
// is high.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_enable_in,
  input  logic [31:0] if_address_in,
  input  logic        mem_enable_in,
  input  logic        mem_read_or_write_in,
  input  logic [2:0]  mem_width_in,
  input  logic [31:0] mem_address_in,
  input  logic [31:0] mem_data_in,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  output logic        mem_busy_out,
  output logic        mem_done_out,
  output logic [31:0] mem_data_out,
  output logic        inst_busy_out,
  output logic        inst_done_out,
  output logic [31:0] inst_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  // Byte count of an access; encodings other than byte/half are words.
  function automatic logic [2:0] width_to_len(input logic [2:0] width);
    logic [2:0] len;
    case (width)
      3'b001:  len = 3'd1;
      3'b010:  len = 3'd2;
      default: len = 3'd4;
    endcase
    return len;
  endfunction

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        w_take_mem;
  logic        w_take_if;
  logic        w_mem_blocked;

  logic        r_is_mem;
  logic [31:0] r_addr;
  logic [2:0]  r_len;
  logic [31:0] r_wdata;
  logic [31:0] r_rbuf;
  logic [2:0]  r_cnt;

  logic [31:0] r_mem_a;
  logic        r_mem_wr;
  logic [7:0]  r_mem_dout;
  logic        r_mem_done;
  logic        r_inst_done;
  logic [31:0] r_mem_data;
  logic [31:0] r_inst;

  logic        w_busy;
  logic        w_accept;
  logic        w_acc_mem;
  logic        w_acc_wr;
  logic [31:0] w_acc_addr;
  logic [2:0]  w_acc_len;
  logic [31:0] w_acc_data;

  logic [2:0]  w_cnt_p1;
  logic [1:0]  w_cap_sel;
  logic [1:0]  w_wr_sel;
  logic [7:0]  w_wr_byte;
  logic [31:0] w_rd_final;
  logic        w_rd_last;
  logic        w_wr_last;

`ifdef IO_FULL_STALL_EN
  // An IO-window store is held off while the UART buffer cannot take it.
  assign w_mem_blocked = mem_read_or_write_in && (mem_address_in[17:16] == 2'b11)
                         && io_buffer_full;
`else
  logic w_unused_io_full;
  assign w_unused_io_full = io_buffer_full;
  assign w_mem_blocked    = 1'b0;
`endif

  // r_cnt counts edges since acceptance. In READ, the byte captured at
  // this edge belongs to the address issued two edges earlier (index r_cnt-1).
  assign w_cnt_p1  = r_cnt + 3'd1;
  assign w_cap_sel = r_cnt[1:0] - 2'd1;
  assign w_wr_sel  = r_cnt[1:0] + 2'd1;
  assign w_wr_byte = r_wdata[{w_wr_sel, 3'b000} +: 8];
  assign w_rd_last = (r_cnt == r_len);
  assign w_wr_last = (w_cnt_p1 == r_len);

  // Read assembly: insert the byte arriving this cycle into the buffer.
  always_comb begin
    w_rd_final = r_rbuf;
    w_rd_final[{w_cap_sel, 3'b000} +: 8] = mem_din;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and arbitration: MEM wins over IF, and only IDLE accepts.
  always_comb begin
    w_state_nxt = r_state;
    w_take_mem  = 1'b0;
    w_take_if   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_enable_in && !w_mem_blocked) begin
          w_take_mem  = 1'b1;
          w_state_nxt = mem_read_or_write_in ? S_WRITE : S_READ;
        end else if (if_enable_in) begin
          w_take_if   = 1'b1;
          w_state_nxt = S_READ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_READ: begin
        if (w_rd_last) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_READ;
        end
      end
      S_WRITE: begin
        if (w_wr_last) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WRITE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode: busy flag and the parameters of the request taken now.
  always_comb begin
    w_busy     = 1'b0;
    w_acc_mem  = 1'b0;
    w_acc_wr   = 1'b0;
    w_acc_addr = 32'd0;
    w_acc_len  = 3'd0;
    w_acc_data = 32'd0;
    if (r_state != S_IDLE) begin
      w_busy = 1'b1;
    end else begin
      w_busy = 1'b0;
    end
    if (w_take_mem) begin
      w_acc_mem  = 1'b1;
      w_acc_wr   = mem_read_or_write_in;
      w_acc_addr = mem_address_in;
      w_acc_len  = width_to_len(mem_width_in);
      w_acc_data = mem_data_in;
    end else if (w_take_if) begin
      w_acc_addr = if_address_in;
      w_acc_len  = 3'd4;
    end else begin
      w_acc_mem = 1'b0;
    end
  end

  assign w_accept = w_take_mem | w_take_if;

  // Datapath: latch the request, drive RAM-side registers, and collect read bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_mem    <= 1'b0;
      r_addr      <= 32'd0;
      r_len       <= 3'd0;
      r_wdata     <= 32'd0;
      r_rbuf      <= 32'd0;
      r_cnt       <= 3'd0;
      r_mem_a     <= 32'd0;
      r_mem_wr    <= 1'b0;
      r_mem_dout  <= 8'd0;
      r_mem_done  <= 1'b0;
      r_inst_done <= 1'b0;
      r_mem_data  <= 32'd0;
      r_inst      <= 32'd0;
    end else begin
      r_mem_done  <= 1'b0;
      r_inst_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_mem <= w_acc_mem;
            r_addr   <= w_acc_addr;
            r_len    <= w_acc_len;
            r_wdata  <= w_acc_data;
            r_rbuf   <= 32'd0;
            r_cnt    <= 3'd0;
            r_mem_a  <= w_acc_addr;
            r_mem_wr <= w_acc_wr;
            if (w_acc_wr) begin
              r_mem_dout <= w_acc_data[7:0];
            end
          end
        end
        S_READ: begin
          r_cnt <= w_cnt_p1;
          if (w_cnt_p1 < r_len) begin
            r_mem_a <= r_addr + {29'd0, w_cnt_p1};
          end
          if (r_cnt != 3'd0) begin
            r_rbuf <= w_rd_final;
          end
          if (w_rd_last) begin
            if (r_is_mem) begin
              r_mem_data <= w_rd_final;
              r_mem_done <= 1'b1;
            end else begin
              r_inst      <= w_rd_final;
              r_inst_done <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          r_cnt <= w_cnt_p1;
          if (w_wr_last) begin
            r_mem_wr <= 1'b0;
            if (r_is_mem) begin
              r_mem_done <= 1'b1;
            end else begin
              r_inst_done <= 1'b1;
            end
          end else begin
            r_mem_a    <= r_addr + {29'd0, w_cnt_p1};
            r_mem_dout <= w_wr_byte;
          end
        end
        default: begin
          r_mem_wr <= 1'b0;
        end
      endcase
    end
  end

  assign mem_a         = r_mem_a;
  assign mem_wr        = r_mem_wr;
  assign mem_dout      = r_mem_dout;
  assign mem_done_out  = r_mem_done;
  assign inst_done_out = r_inst_done;
  assign mem_data_out  = r_mem_data;
  assign inst_out      = r_inst;
  assign mem_busy_out  = w_busy;
  assign inst_busy_out = w_busy;

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller between the MEM/IF stages and the 8-bit unified RAM/IO bus. Arbitrates one instruction-fetch requester and one data requester, serialises 1/2/4-byte accesses into byte transfers on the RAM port, and returns assembled little-endian data with a one-cycle done pulse. Sits directly downstream of the MEM stage and consumes its `mc_*` request outputs.

## Interface
- No parameters.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_enable_in` in 1: IF word-read request (level).
- `if_address_in` in 32: IF fetch address.
- `mem_enable_in` in 1: MEM request (level).
- `mem_read_or_write_in` in 1: 0 = read, 1 = write.
- `mem_width_in` in 3: 001 byte, 010 half, 100 word; any other value is treated as word.
- `mem_address_in` in 32: data address.
- `mem_data_in` in 32: store data; low bytes used.
- `io_buffer_full` in 1: UART buffer full. Used only under `IO_FULL_STALL_EN`.
- `mem_din` in 8: RAM read byte.
- `mem_dout` out 8: RAM write byte.
- `mem_a` out 32: RAM byte address.
- `mem_wr` out 1: 1 = write.
- `mem_busy_out` out 1: controller engaged; the MEM stage must not assert a new request.
- `mem_done_out` out 1: one-cycle completion pulse for a MEM access.
- `mem_data_out` out 32: read data, zero-extended to the access width.
- `inst_busy_out` out 1: same meaning as `mem_busy_out`, for IF.
- `inst_done_out` out 1: one-cycle completion pulse for an IF fetch.
- `inst_out` out 32: fetched instruction.

## Operation
- States: IDLE, READ, WRITE. The served requester (IF or MEM) is latched on acceptance.
- Acceptance happens only in IDLE. Accepting in the same cycle as a done pulse is allowed.
- Arbitration:
  - MEM has priority over IF.
  - The losing IF request is not latched; IF keeps its level asserted and is accepted later.
- On acceptance, the controller latches address, width (IF is always 4 bytes), data, and requester, and clears the byte counter.
- READ:
  - Issues addresses `addr+0 .. addr+N-1` on consecutive cycles.
  - Captures `mem_din` two edges after each address is issued.
  - Byte k goes to bits [8k+7:8k]; bits above 8N are 0.
- WRITE:
  - Drives `mem_wr=1`, `mem_a=addr+k`, `mem_dout=data[8k+7:8k]` for k = 0..N-1 on consecutive cycles.
  - Then drops `mem_wr` and returns to IDLE.
- Address increment is 32-bit modular: `0xFFFFFFFF+1` wraps to 0.
- `busy_out` outputs equal (state != IDLE). Both are combinational from the state register.
- Done pulse and data registers:
  - Exactly one of `mem_done_out` / `inst_done_out` pulses, according to the latched requester.
  - `mem_data_out` / `inst_out` hold their value until the next completion for that requester.
- Sign extension is left to the MEM stage; this block only zero-fills.
- Requests arriving while busy are ignored, not queued.
- Reset, including mid-transfer: aborts the transfer and forces IDLE. All outputs read 0: `mem_a=0`, `mem_wr=0`, `mem_dout=0`, both busy outputs 0, both done pulses 0, `mem_data_out=0`, `inst_out=0`.

## Timing
- Acceptance is at edge E0.
- All RAM-side outputs are registered: `mem_a`, `mem_wr`, and `mem_dout` for byte k change at E_k.
- RAM read latency is one cycle after it samples the address. Byte k is therefore captured at E_(k+2).
- Read of N bytes: done pulse and data registered at E_(N+1). LB/LBU at E2, LH/LHU at E3, LW/IF at E5.
- Write of N bytes: done pulse registered at E_N, with `mem_wr` returning to 0 at the same edge. SB at E1, SH at E2, SW at E4.
- Busy outputs go high from E0 through the done edge, and are low during the done-pulse cycle.
- Back-to-back accesses: next acceptance at the done edge plus one at the earliest. No idle bubble beyond the done cycle.

## Configuration
- `IO_FULL_STALL_EN` defined:
  - A MEM write with `address[17:16]==2'b11` is not accepted while `io_buffer_full=1`.
  - In that case a pending IF request may be accepted instead.
  - The write is accepted in the first IDLE cycle with `io_buffer_full=0`.
- `IO_FULL_STALL_EN` undefined: `io_buffer_full` is ignored and all requests are accepted immediately.

## Test plan
- IF word fetch at 0x00000100, RAM bytes 13,05,00,00 → `inst_out=0x00000513`, with `inst_done_out` pulsing one cycle after E5.
- MEM LB at 0x0000_0203, RAM byte 0x80 → `mem_data_out=0x00000080` at E2. LH at 0x200 with bytes 34,12 → `0x00001234` at E3.
- MEM SW of 0xDEADBEEF to 0x1000 → `mem_wr=1` with (a, dout) = (1000,EF), (1001,BE), (1002,AD), (1003,DE) on E0..E3, and `mem_done_out` at E4.
- IF and MEM request in the same IDLE cycle → MEM served first, IF accepted at the edge after MEM done, with no lost request. SW to 0xFFFFFFFE wraps: `mem_a` = FFFFFFFE, FFFFFFFF, 0, 1.
- Assert `rst` at E2 of an LW → all outputs 0 immediately. After release, a new LB completes normally.
- With `IO_FULL_STALL_EN` defined: SB to 0x30000 while `io_buffer_full=1` for 3 cycles → no `mem_wr` during those cycles, write issued after full drops, `mem_done_out` one edge later.
